// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART byte transmitter among NREQ requesters.
// Optional stall watchdog enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned TOW     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [8*NREQ-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_busy_i,
    output logic [IDW-1:0]    grant_id_o,
    output logic              grant_active_o,
    output logic              pkt_done_o,
    output logic              timeout_err_o
);

    if ((NREQ < 2) || (NREQ > 8) || ((1 << IDW) < NREQ) || (TIMEOUT >= (1 << TOW))) begin : g_bad_cfg
        $error("uart_tx_arbiter: inconsistent NREQ/IDW/TIMEOUT/TOW");
    end

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic            grant_active_q, grant_active_d;
    logic            pkt_done_q, pkt_done_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            last_q, last_d;

    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic            owner_valid;
    logic            xfer;

`ifdef UART_ARB_TIMEOUT_EN
    logic [TOW-1:0]  to_cnt_q, to_cnt_d;
    logic            to_err_q, to_err_d;
    logic            stall;
`endif

    // Round-robin winner: first valid requester after the last owner.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            int unsigned idx;
            idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!win_found && req_valid_i[IDW'(idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    assign owner_valid = req_valid_i[grant_id_q];
    assign xfer        = (state_q == SEND) && owner_valid && !tx_busy_i;

    // Handshake is combinational from registered state; suppressed during reset.
    always_comb begin
        req_ready_o = '0;
        if (xfer && !rst) begin
            req_ready_o = NREQ'(1) << grant_id_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        tx_data_d      = tx_data_q;
        tx_start_d     = 1'b0;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        pkt_done_d     = 1'b0;
        rr_ptr_d       = rr_ptr_q;
        last_d         = last_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_id_d     = win_id;
                    grant_active_d = 1'b1;
                    state_d        = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    tx_data_d  = req_data_i[8*grant_id_q +: 8];
                    tx_start_d = 1'b1;
                    last_d     = req_last_i[grant_id_q];
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    if (last_q) begin
                        state_d        = IDLE;
                        pkt_done_d     = 1'b1;
                        rr_ptr_d       = grant_id_q;
                        grant_active_d = 1'b0;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: counts owner stalls in SEND and missing busy rise in WAIT_BUSY.
        to_cnt_d = '0;
        to_err_d = 1'b0;
        stall    = 1'b0;
        case (state_q)
            SEND: begin
                if (!xfer && !owner_valid) begin
                    to_cnt_d = to_cnt_q + TOW'(1);
                    stall    = 1'b1;
                end else if (!xfer) begin
                    to_cnt_d = to_cnt_q;
                end
            end
            WAIT_BUSY: begin
                if (!tx_busy_i) begin
                    to_cnt_d = to_cnt_q + TOW'(1);
                    stall    = 1'b1;
                end
            end
            default: to_cnt_d = '0;
        endcase
        if (stall && (to_cnt_d == TOW'(TIMEOUT))) begin
            to_err_d       = 1'b1;
            to_cnt_d       = '0;
            state_d        = IDLE;
            grant_active_d = 1'b0;
            rr_ptr_d       = grant_id_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            tx_data_q      <= '0;
            tx_start_q     <= 1'b0;
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            pkt_done_q     <= 1'b0;
            rr_ptr_q       <= IDW'(NREQ - 1);
            last_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tx_data_q      <= tx_data_d;
            tx_start_q     <= tx_start_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            pkt_done_q     <= pkt_done_d;
            rr_ptr_q       <= rr_ptr_d;
            last_q         <= last_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign timeout_err_o = to_err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

    assign tx_data_o      = tx_data_q;
    assign tx_start_o     = tx_start_q;
    assign grant_id_o     = grant_id_q;
    assign grant_active_o = grant_active_q;
    assign pkt_done_o     = pkt_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned IDW      = 2;
    localparam int          BUSY_LEN = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic [IDW-1:0]    grant_id;
    logic              grant_active;
    logic              pkt_done;
    logic              timeout_err;

    uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(50000), .TOW(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_last_i     (req_last),
        .req_ready_o    (req_ready),
        .tx_data_o      (tx_data),
        .tx_start_o     (tx_start),
        .tx_busy_i      (tx_busy),
        .grant_id_o     (grant_id),
        .grant_active_o (grant_active),
        .pkt_done_o     (pkt_done),
        .timeout_err_o  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Requester packet queues: bit 8 marks the last byte of a packet.
    logic [8:0]      rq [NREQ][$];
    logic [NREQ-1:0] stall_req;
    logic            busy_force;
    int              busy_cnt;
    logic [NREQ-1:0] ready_seen;
    logic            start_seen;

    int          glog [$];
    logic [7:0]  txlog [$];
    int          done_cnt;
    int          ready_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int rr);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (rr + k) % NREQ;
            if (v[IDW'(j)]) return j;
        end
        return 0;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]       = !stall_req[i];
                req_data[8*i +: 8] = rq[i][0][7:0];
                req_last[i]        = rq[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        tx_busy = busy_force || (busy_cnt > 0);
    endtask

    // One clock: consume handshakes, advance the transmitter model, re-drive inputs.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (ready_seen[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        if (start_seen) busy_cnt = BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt--;
        drive();
    endtask

    task automatic wait_quiet(input string name, input int maxc);
        int  c;
        logic pend;
        c = 0;
        forever begin
            pend = 1'b0;
            for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) pend = 1'b1;
            if (!(pend || grant_active || busy_cnt > 0 || tx_busy) || c >= maxc) break;
            step();
            c++;
        end
        chk({name, "_drain_in_budget"}, 32'(c < maxc), 32'd1);
        repeat (3) step();
    endtask

    task automatic clear_logs();
        glog.delete();
        txlog.delete();
        done_cnt  = 0;
        ready_cnt = 0;
    endtask

    // Packet-level reference model, evaluated and compared on every falling edge.
    logic       prev_rst = 1'b1;
    logic       prev_ga  = 1'b0;
    logic       m_active, m_inflight, m_seenbusy, m_curlast, e_start, e_done;
    int         m_owner, m_gid, m_rr;
    logic [7:0] m_txd;

    always @(negedge clk) begin
        logic [NREQ-1:0] e_ready;
        if (prev_rst) begin
            m_active   = 1'b0;
            m_inflight = 1'b0;
            m_seenbusy = 1'b0;
            m_curlast  = 1'b0;
            e_start    = 1'b0;
            e_done     = 1'b0;
            m_owner    = 0;
            m_gid      = 0;
            m_rr       = NREQ - 1;
            m_txd      = 8'h00;
        end
        e_ready = '0;
        if (!rst && m_active && !m_inflight && req_valid[IDW'(m_owner)] && !tx_busy)
            e_ready[IDW'(m_owner)] = 1'b1;

        chk("req_ready",    32'(req_ready),    32'(e_ready));
        chk("grant_active", 32'(grant_active), 32'(m_active));
        chk("grant_id",     32'(grant_id),     32'(m_gid));
        chk("tx_start",     32'(tx_start),     32'(e_start));
        chk("tx_data",      32'(tx_data),      32'(m_txd));
        chk("pkt_done",     32'(pkt_done),     32'(e_done));
        chk("timeout_err",  32'(timeout_err),  32'd0);

        if (grant_active && !prev_ga) glog.push_back(int'(grant_id));
        if (tx_start) txlog.push_back(tx_data);
        if (pkt_done) done_cnt++;
        if (req_ready != '0) ready_cnt++;
        prev_ga    = grant_active;
        ready_seen = req_ready;
        start_seen = tx_start;

        e_start = 1'b0;
        e_done  = 1'b0;
        if (!rst) begin
            if (!m_active) begin
                if (req_valid != '0) begin
                    m_owner  = pick(req_valid, m_rr);
                    m_gid    = m_owner;
                    m_active = 1'b1;
                end
            end else if (!m_inflight) begin
                if (e_ready != '0) begin
                    m_inflight = 1'b1;
                    m_seenbusy = 1'b0;
                    m_curlast  = req_last[IDW'(m_owner)];
                    m_txd      = req_data[8*m_owner +: 8];
                    e_start    = 1'b1;
                end
            end else if (tx_busy) begin
                m_seenbusy = 1'b1;
            end else if (m_seenbusy) begin
                m_inflight = 1'b0;
                if (m_curlast) begin
                    e_done   = 1'b1;
                    m_active = 1'b0;
                    m_rr     = m_owner;
                end
            end
        end
        prev_rst = rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst        = 1'b1;
        stall_req  = '0;
        busy_force = 1'b0;
        busy_cnt   = 0;
        ready_seen = '0;
        start_seen = 1'b0;
        clear_logs();
        // Reset with every requester valid, then round-robin over 1-byte packets.
        for (int i = 0; i < NREQ; i++) begin
            rq[i].push_back(9'h100 | 9'(8'hA0 + i));
            rq[i].push_back(9'h100 | 9'(8'hB0 + i));
        end
        drive();
        repeat (3) step();
        chk("rst_req_ready",    32'(req_ready),    32'd0);
        chk("rst_grant_active", 32'(grant_active), 32'd0);
        chk("rst_tx_start",     32'(tx_start),     32'd0);
        rst = 1'b0;
        wait_quiet("rr", 600);
        chk("rr_grants", 32'(glog.size()), 32'd8);
        chk("rr_g0", 32'(glog[0]), 32'd0);
        chk("rr_g1", 32'(glog[1]), 32'd1);
        chk("rr_g2", 32'(glog[2]), 32'd2);
        chk("rr_g3", 32'(glog[3]), 32'd3);
        chk("rr_g4", 32'(glog[4]), 32'd0);
        chk("rr_tx0", 32'(txlog[0]), 32'hA0);
        chk("rr_tx4", 32'(txlog[4]), 32'hB0);

        // Single two-byte packet from requester 0.
        clear_logs();
        rq[0].push_back(9'h069);
        rq[0].push_back(9'h120);
        wait_quiet("single", 200);
        chk("single_n",    32'(txlog.size()), 32'd2);
        chk("single_tx0",  32'(txlog[0]),     32'h69);
        chk("single_tx1",  32'(txlog[1]),     32'h20);
        chk("single_done", 32'(done_cnt),     32'd1);

        // Requester 1 holds the transmitter for its whole packet while 2 waits.
        clear_logs();
        rq[1].push_back(9'h011);
        rq[1].push_back(9'h012);
        rq[1].push_back(9'h113);
        rq[2].push_back(9'h121);
        wait_quiet("hold", 300);
        chk("hold_g0",  32'(glog[0]),  32'd1);
        chk("hold_g1",  32'(glog[1]),  32'd2);
        chk("hold_tx2", 32'(txlog[2]), 32'h13);
        chk("hold_tx3", 32'(txlog[3]), 32'h21);

        // Transmitter busy while SEND is entered: no handshake until it clears.
        clear_logs();
        busy_force = 1'b1;
        rq[3].push_back(9'h133);
        drive();
        repeat (8) step();
        chk("busy_no_ready", 32'(ready_cnt),    32'd0);
        chk("busy_granted",  32'(grant_active), 32'd1);
        chk("busy_owner",    32'(grant_id),     32'd3);
        busy_force = 1'b0;
        wait_quiet("busy", 200);
        chk("busy_tx0", 32'(txlog[0]), 32'h33);

        // Owner drops valid for 20 cycles mid-packet; grant is held.
        clear_logs();
        rq[0].push_back(9'h001);
        rq[0].push_back(9'h002);
        rq[0].push_back(9'h103);
        c = 0;
        while (rq[0].size() != 2 && c < 50) begin step(); c++; end
        chk("stall_first_byte", 32'(c < 50), 32'd1);
        stall_req[0] = 1'b1;
        repeat (20) step();
        chk("stall_held",  32'(grant_active), 32'd1);
        chk("stall_owner", 32'(grant_id),     32'd0);
        chk("stall_n",     32'(txlog.size()), 32'd1);
        stall_req[0] = 1'b0;
        wait_quiet("stall", 300);
        chk("stall_tx1",  32'(txlog[1]), 32'h02);
        chk("stall_tx2",  32'(txlog[2]), 32'h03);
        chk("stall_done", 32'(done_cnt), 32'd1);

        // Reset mid-packet: arbiter returns to idle, next grant uses reset priority.
        clear_logs();
        rq[1].push_back(9'h041);
        rq[1].push_back(9'h042);
        rq[1].push_back(9'h143);
        c = 0;
        while (txlog.size() == 0 && c < 50) begin step(); c++; end
        chk("mid_rst_started", 32'(c < 50), 32'd1);
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        drive();
        step();
        chk("mid_rst_tx_start", 32'(tx_start),     32'd0);
        chk("mid_rst_active",   32'(grant_active), 32'd0);
        chk("mid_rst_gid",      32'(grant_id),     32'd0);
        rst = 1'b0;
        wait_quiet("mid_rst", 100);
        clear_logs();
        rq[2].push_back(9'h155);
        rq[3].push_back(9'h156);
        wait_quiet("post_rst", 200);
        chk("post_rst_g0", 32'(glog[0]), 32'd2);
        chk("post_rst_g1", 32'(glog[1]), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
